// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and helpers for the write-back arbiter
package wb_arbiter_pkg;

  localparam int DEF_D_SIZE = 32;
  localparam int DEF_DEST_W = 4;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// rtl/wb_chan_fifo.sv - per-channel in-order result FIFO
module wb_chan_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DEF_DEST_W + DEF_D_SIZE,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = idx_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges NUM_CH result channels onto one register-file write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int D_SIZE     = DEF_D_SIZE,
  parameter int DEST_W     = DEF_DEST_W,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int PRIO_MODE  = PRIO_RR,
  localparam int CH_W      = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DEST_W-1:0] in_dest,
  input  logic [NUM_CH*D_SIZE-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     wr_en,
  output logic [DEST_W-1:0]        wr_dest,
  output logic [D_SIZE-1:0]        wr_data,
  output logic [CH_W-1:0]          wr_ch,
  output logic                     busy
);

  localparam int WIDTH = DEST_W + D_SIZE;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DEST_W-1:0] OOB_REG = '1;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [WIDTH-1:0]  head  [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_valid;
  int                idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DEST_W-1:0] dest;
    assign dest        = in_dest[i*DEST_W +: DEST_W];
    assign in_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
    // OOB results complete the handshake but never occupy a slot.
    assign push[i]     = in_valid[i] && !full[i] && (dest != OOB_REG);
    assign pop[i]      = grant_valid && (grant_ch == CH_W'(i));

    wb_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata ({dest, in_data[i*D_SIZE +: D_SIZE]}),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

  // Later loop iterations override earlier ones, so the last hit is the winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    if (PRIO_MODE == PRIO_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!empty[i]) begin
          grant_valid = 1'b1;
          grant_ch    = CH_W'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!empty[idx]) begin
          grant_valid = 1'b1;
          grant_ch    = CH_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_dest <= OOB_REG;
      wr_data <= '0;
      wr_ch   <= '0;
      rr_ptr  <= CH_W'(NUM_CH - 1);
    end else if (grant_valid) begin
      wr_en              <= 1'b1;
      {wr_dest, wr_data} <= head[grant_ch];
      wr_ch              <= grant_ch;
      rr_ptr             <= grant_ch;
    end else begin
      wr_en   <= 1'b0;
      wr_dest <= OOB_REG;
    end
  end

  assign busy = (|(~empty)) | wr_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (round-robin and fixed priority)
module tb_wb_arbiter;

  localparam int NCH   = 2;
  localparam int DW    = 4;
  localparam int DS    = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  p_valid;
  logic [7:0]  in_dest;
  logic [63:0] in_data;

  logic [1:0]  r_ready, p_ready;
  logic        r_wr_en, p_wr_en;
  logic [3:0]  r_wr_dest, p_wr_dest;
  logic [31:0] r_wr_data, p_wr_data;
  logic [0:0]  r_wr_ch, p_wr_ch;
  logic        r_busy, p_busy;

  always #5 clk = ~clk;

  wb_arbiter #(.D_SIZE(DS), .DEST_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
    .in_ready(r_ready), .wr_en(r_wr_en), .wr_dest(r_wr_dest), .wr_data(r_wr_data),
    .wr_ch(r_wr_ch), .busy(r_busy)
  );

  wb_arbiter #(.D_SIZE(DS), .DEST_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_dest(in_dest), .in_data(in_data),
    .in_ready(p_ready), .wr_en(p_wr_en), .wr_dest(p_wr_dest), .wr_data(p_wr_data),
    .wr_ch(p_wr_ch), .busy(p_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the round-robin instance: one tagged queue of pending results.
  typedef struct {
    int          ch;
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic        m_wr_en;
  logic [3:0]  m_wr_dest;
  logic [31:0] m_wr_data;
  logic        m_wr_ch;
  int          m_last;
  logic [1:0]  hs;

  function automatic int m_count(input int c);
    int n = 0;
    foreach (mq[k]) if (mq[k].ch == c) n++;
    return n;
  endfunction

  function automatic logic [1:0] m_ready();
    return {m_count(1) < DEPTH, m_count(0) < DEPTH};
  endfunction

  task automatic model_step();
    int cnt[2];
    int g;
    if (rst) begin
      mq.delete();
      m_wr_en = 1'b0; m_wr_dest = 4'hF; m_wr_data = '0; m_wr_ch = 1'b0;
      m_last = NCH - 1; hs = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      cnt[c] = m_count(c);
      hs[c]  = in_valid[c] && (cnt[c] < DEPTH);
    end
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_last + k) % NCH;
      if (g < 0 && cnt[c] > 0) g = c;
    end
    if (g >= 0) begin
      for (int k = 0; k < mq.size(); k++) begin
        if (mq[k].ch == g) begin
          m_wr_en = 1'b1; m_wr_dest = mq[k].d; m_wr_data = mq[k].v; m_wr_ch = (g == 1);
          mq.delete(k);
          break;
        end
      end
      m_last = g;
    end else begin
      m_wr_en = 1'b0; m_wr_dest = 4'hF;
    end
    for (int c = 0; c < NCH; c++) begin
      if (hs[c] && in_dest[c*4 +: 4] != 4'hF)
        mq.push_back('{ch: c, d: in_dest[c*4 +: 4], v: in_data[c*32 +: 32]});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; p_valid = '0; in_dest = '0; in_data = '0;
    tick(); tick();
    checks++;
    if ({r_wr_en, r_wr_dest, r_busy} !== {1'b0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", {r_wr_en, r_wr_dest, r_busy}, 6'b0_1111_0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({r_wr_en, r_wr_dest, r_ready, r_busy} !== {1'b0, 4'hF, 2'b11, 1'b0}) begin
        errors++; $display("FAIL idle_rr cyc=%0d got=%b exp=%b", i, {r_wr_en, r_wr_dest, r_ready, r_busy}, 8'b0_1111_11_0);
      end
      checks++;
      if ({p_wr_en, p_wr_dest, p_ready, p_busy} !== {1'b0, 4'hF, 2'b11, 1'b0}) begin
        errors++; $display("FAIL idle_fp cyc=%0d got=%b exp=%b", i, {p_wr_en, p_wr_dest, p_ready, p_busy}, 8'b0_1111_11_0);
      end
    end
    checks++;
    if ({r_wr_data, r_wr_ch} !== 33'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {r_wr_data, r_wr_ch});
    end
  endtask

  task automatic test_single();
    in_dest[3:0] = 4'd3; in_data[31:0] = 32'h1234; in_valid = 2'b01;
    tick();
    in_valid = '0;
    checks++;
    if ({r_wr_en, r_busy} !== 2'b01) begin
      errors++; $display("FAIL single_t1 got=%b exp=01", {r_wr_en, r_busy});
    end
    tick();
    checks++;
    if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== {1'b1, 4'd3, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL single_t2 got=%h exp=%h", {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, {1'b1, 4'd3, 32'h1234, 1'b0});
    end
    tick();
    checks++;
    if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== {1'b0, 4'hF, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL single_t3 got=%h exp=%h", {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, {1'b0, 4'hF, 32'h1234, 1'b0});
    end
  endtask

  task automatic test_collision();
    logic [37:0] wa, wb;
    wa = {1'b1, 4'd1, 32'hA, 1'b0};
    wb = {1'b1, 4'd2, 32'hB, 1'b1};
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int r = 0; r < 2; r++) begin
      in_dest = {4'd2, 4'd1}; in_data = {32'hB, 32'hA};
      in_valid = 2'b11; p_valid = (r == 0) ? 2'b11 : 2'b00;
      tick();
      in_valid = '0; p_valid = '0;
      checks++;
      if (r_wr_en !== 1'b0) begin errors++; $display("FAIL coll_lat r=%0d got=%b exp=0", r, r_wr_en); end
      tick();
      checks++;
      if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== wa) begin
        errors++; $display("FAIL coll_rr_first r=%0d got=%h exp=%h", r, {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, wa);
      end
      if (r == 0) begin
        checks++;
        if ({p_wr_en, p_wr_dest, p_wr_data, p_wr_ch} !== wb) begin
          errors++; $display("FAIL coll_fp_first got=%h exp=%h", {p_wr_en, p_wr_dest, p_wr_data, p_wr_ch}, wb);
        end
      end
      tick();
      checks++;
      if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== wb) begin
        errors++; $display("FAIL coll_rr_second r=%0d got=%h exp=%h", r, {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, wb);
      end
      if (r == 0) begin
        checks++;
        if ({p_wr_en, p_wr_dest, p_wr_data, p_wr_ch} !== wa) begin
          errors++; $display("FAIL coll_fp_second got=%h exp=%h", {p_wr_en, p_wr_dest, p_wr_data, p_wr_ch}, wa);
        end
      end
      tick();
      checks++;
      if ({r_wr_en, r_busy} !== 2'b00) begin
        errors++; $display("FAIL coll_done r=%0d got=%b exp=00", r, {r_wr_en, r_busy});
      end
    end
  endtask

  task automatic test_backpressure();
    int          k0, n1, cyc;
    logic        saw_drop;
    logic [31:0] got[$];
    rst = 1'b1; tick(); rst = 1'b0;
    k0 = 0; n1 = 0; saw_drop = 1'b0; cyc = 0;
    while (got.size() < 5 && cyc < 80) begin
      in_valid      = {1'b1, k0 < 5};
      in_dest[3:0]  = 4'(1 + k0);
      in_data[31:0] = 32'hC0DE_0000 + 32'(k0);
      in_dest[7:4]  = 4'(8 + n1 % 7);
      in_data[63:32] = 32'h1000 + 32'(n1);
      tick();
      if (hs[0]) k0++;
      if (hs[1]) n1++;
      cyc++;
      if (r_ready[0] === 1'b0) saw_drop = 1'b1;
      if (r_wr_en === 1'b1 && r_wr_ch === 1'b0) got.push_back(r_wr_data);
      checks++;
      if (r_ready !== m_ready()) begin
        errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, r_ready, m_ready());
      end
      checks++;
      if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== {m_wr_en, m_wr_dest, m_wr_data, m_wr_ch}) begin
        errors++; $display("FAIL bp_out cyc=%0d got=%h exp=%h", cyc, {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, {m_wr_en, m_wr_dest, m_wr_data, m_wr_ch});
      end
    end
    in_valid = '0;
    checks++;
    if (saw_drop !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got=%b exp=1", saw_drop); end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL bp_count got=%0d exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 32'hC0DE_0000 + 32'(i)) begin
          errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], 32'hC0DE_0000 + 32'(i));
        end
      end
    end
    cyc = 0;
    while (r_busy !== 1'b0 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (r_busy !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", r_busy); end
  endtask

  task automatic test_oob_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    in_dest[7:4] = 4'hF; in_data[63:32] = 32'hDEAD; in_valid = 2'b10;
    checks++;
    if (r_ready[1] !== 1'b1) begin errors++; $display("FAIL oob_ready got=%b exp=1", r_ready[1]); end
    tick();
    in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r_wr_en, r_busy} !== 2'b00) begin errors++; $display("FAIL oob_nowrite cyc=%0d got=%b exp=00", i, {r_wr_en, r_busy}); end
      tick();
    end
    in_dest = {4'd6, 4'd5}; in_data = {32'h66, 32'h55}; in_valid = 2'b11;
    tick();
    in_valid = '0;
    checks++;
    if (r_busy !== 1'b1) begin errors++; $display("FAIL mid_queued got=%b exp=1", r_busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (r_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b exp=0", r_wr_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({r_wr_en, r_ready, r_busy} !== 4'b0_11_0) begin
        errors++; $display("FAIL mid_after cyc=%0d got=%b exp=0110", i, {r_wr_en, r_ready, r_busy});
      end
    end
    in_dest[7:4] = 4'd7; in_data[63:32] = 32'h77; in_valid = 2'b10;
    tick();
    in_valid = '0;
    tick();
    checks++;
    if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== {1'b1, 4'd7, 32'h77, 1'b1}) begin
      errors++; $display("FAIL mid_newpush got=%h exp=%h", {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, {1'b1, 4'd7, 32'h77, 1'b1});
    end
    tick();
  endtask

  task automatic test_random();
    logic        pend[2];
    logic [3:0]  pd[2];
    logic [31:0] pv[2];
    int          cyc;
    pend[0] = 1'b0; pend[1] = 1'b0; pd[0] = '0; pd[1] = '0; pv[0] = '0; pv[1] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 55) begin
          pend[c] = 1'b1; pd[c] = 4'($urandom_range(0, 15)); pv[c] = $urandom;
        end
        in_valid[c] = pend[c]; in_dest[c*4 +: 4] = pd[c]; in_data[c*32 +: 32] = pv[c];
      end
      tick();
      for (int c = 0; c < NCH; c++) if (hs[c]) pend[c] = 1'b0;
      checks++;
      if ({r_wr_en, r_wr_dest, r_wr_data, r_wr_ch} !== {m_wr_en, m_wr_dest, m_wr_data, m_wr_ch}) begin
        errors++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", n, {r_wr_en, r_wr_dest, r_wr_data, r_wr_ch}, {m_wr_en, m_wr_dest, m_wr_data, m_wr_ch});
      end
      checks++;
      if ({r_ready, r_busy} !== {m_ready(), (mq.size() != 0) || m_wr_en}) begin
        errors++; $display("FAIL rnd_status cyc=%0d got=%b exp=%b", n, {r_ready, r_busy}, {m_ready(), (mq.size() != 0) || m_wr_en});
      end
    end
    in_valid = '0;
    cyc = 0;
    while (r_busy !== 1'b0 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if ({r_busy, mq.size() == 0} !== 2'b01) begin
      errors++; $display("FAIL rnd_drain got=%b exp=01", {r_busy, mq.size() == 0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_backpressure();
    test_oob_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised write-back stage that merges results from NUM_CH execution pipelines (integer EXEC, FPU, future units) onto the single register-file write port.
- Each channel has a small FIFO, so a write-port collision queues the loser instead of stalling the whole pipeline.
- Winners are chosen by round-robin or fixed priority.
- Sits between the execute stages and the register block; its outputs drive the register-file write port.

Parameters:
- D_SIZE, 32: result data width.
- DEST_W, 4: destination field width. The all-ones value is OOB_REG, meaning "no write".
- NUM_CH, 2: number of producer channels (2..8).
- FIFO_DEPTH, 2: entries per channel FIFO (power of two, 1..8).
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, where the highest channel index wins (FPU on the top channel).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel result valid.
- in_dest  in  NUM_CH*DEST_W  per-channel destination; channel i occupies bits [i*DEST_W +: DEST_W].
- in_data  in  NUM_CH*D_SIZE  per-channel result, packed the same way.
- in_ready  out  NUM_CH  channel i can accept this cycle.
- wr_en  out  1  register-file write enable.
- wr_dest  out  DEST_W  register-file write address.
- wr_data  out  D_SIZE  register-file write data.
- wr_ch  out  clog2(NUM_CH)  channel that produced the current write.
- busy  out  1  any FIFO non-empty or wr_en high.

Behaviour:
- One clock (clk). rst is synchronous and active-high. It is sampled only on the rising edge of clk.
- Reset values:
  - wr_en=0, wr_dest=OOB_REG, wr_data=0, wr_ch=0, busy=0.
  - All FIFOs are empty. in_ready is all-ones in the cycle after reset.
  - The round-robin pointer resets to NUM_CH-1, so channel 0 is first served.
- Reset mid-operation discards all queued entries. No write is issued in the reset cycle or the cycle after.
- Handshake:
  - A transfer on channel i occurs when in_valid[i] && in_ready[i] at the clock edge.
  - in_ready[i] = (count_i < FIFO_DEPTH). It depends only on the registered count, not on a same-cycle pop.
  - Producers must hold dest/data stable while valid && !ready.
- OOB filter: a transfer with in_dest == OOB_REG completes the handshake but is not enqueued.
- FIFOs:
  - Each channel FIFO is strictly in order.
  - A simultaneous push and pop on a full FIFO is not allowed, because ready is low.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Arbitration each cycle among non-empty FIFOs:
  - PRIO_MODE=0: search from pointer+1 upward, wrapping. The pointer updates to the granted channel only when a grant occurs.
  - PRIO_MODE=1: the highest non-empty index wins. No pointer is kept.
  - Exactly one FIFO is popped per cycle when any FIFO is non-empty.
- Output register:
  - On a grant, wr_en<=1, with wr_dest, wr_data and wr_ch taken from the head of the granted FIFO.
  - With no grant, wr_en<=0 and wr_dest<=OOB_REG. wr_data and wr_ch hold their values.
- Latency: push at edge t → entry at head after t → grant in cycle t+1 → wr_en high in cycle t+2 if uncontended. Each extra contending entry ahead adds 1 cycle.
- Throughput: 1 write per cycle sustained.
- Ordering:
  - Guaranteed within a channel.
  - Not guaranteed across channels. Same-destination hazards across units are resolved upstream by the hazard unit.
- busy = |(~empty) | wr_en, combinational from registered state.

Decomposition:
- The shared header seq_core.vh holds D_SIZE, REG_A_SIZE-derived DEST_W, and OUT_OF_BOUND_REG (= OOB_REG).
- The packing macros for the per-channel slices also go in seq_core.vh.
- One sub-module, wb_chan_fifo, implements the per-channel FIFO:
  - parameters DEPTH, WIDTH=DEST_W+D_SIZE;
  - push, pop, full, empty and count ports.
- Arbiter and output register stay in wb_arbiter.

Test Plan:
- Reset and idle: assert rst 2 cycles, then release with no traffic → wr_en=0, wr_dest=4'hF, in_ready=2'b11, busy=0 throughout.
- Single write: ch0 pushes dest=3, data=32'h1234 at edge t → wr_en=1, wr_dest=3, wr_data=32'h1234, wr_ch=0 in cycle t+2, wr_en=0 in cycle t+3.
- Collision, round-robin (NUM_CH=2): ch0 pushes (1, 0xA) and ch1 pushes (2, 0xB) at the same edge → writes (1, 0xA, ch0) then (2, 0xB, ch1) on consecutive cycles. A repeat of the same pair next round starts with ch0, since the pointer sits on 1.
- Collision, fixed priority (PRIO_MODE=1): same stimulus → (2, 0xB, ch1) first, then (1, 0xA, ch0).
- Backpressure and wrap (FIFO_DEPTH=2): ch0 holds valid for 5 back-to-back entries while ch1 saturates → ch0 in_ready drops when its count reaches 2. All 5 ch0 entries are written in push order, and no entry is lost or duplicated across pointer wrap.
- OOB drop and mid-run reset: ch1 pushes dest=4'hF → handshake completes, no write occurs. Then with 2 entries queued, assert rst for 1 cycle → queued writes never appear, and wr_en stays 0 until a new push.
